// File: rtl/sp_ram_pkg.sv
// Shared encodings for the single-port RAM and its request front-end.
package sp_ram_pkg;

  localparam logic W_R_WRITE = 1'b1;
  localparam logic W_R_READ  = 1'b0;

  typedef enum logic {StIdle, StCapt} state_e;
  typedef enum logic {GntWr, GntRd} grant_e;

endpackage

// File: rtl/sp_ram.sv
// Single-port RAM: synchronous write, registered read, data_out driven only while en & ~w_r.
module sp_ram
  import sp_ram_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 4,
  parameter int unsigned DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     w_r,
  input  logic [ADDRESS_WIDTH-1:0] add,
  input  logic [DATA_WIDTH-1:0]    data_in,
  output logic [DATA_WIDTH-1:0]    data_out
);

  logic [DATA_WIDTH-1:0] mem [1 << ADDRESS_WIDTH];
  logic [DATA_WIDTH-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (en && w_r == W_R_WRITE) mem[add] <= data_in;
    if (en && w_r == W_R_READ)  rd_q     <= mem[add];
  end

  assign data_out = (en && w_r == W_R_READ) ? rd_q : {DATA_WIDTH{1'bz}};

endmodule

// File: rtl/sp_ram_ctrl.sv
// Arbitrates independent write/read request streams onto the single RAM port and returns
// registered read responses two cycles after the read grant.
module sp_ram_ctrl
  import sp_ram_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 4,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned DEPTH         = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [ADDRESS_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     rd_valid,
  output logic                     rd_ready,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic                     rsp_valid,
  output logic [DATA_WIDTH-1:0]    rsp_data,
  output logic                     err_addr,
  output logic                     ram_en,
  output logic                     ram_w_r,
  output logic [ADDRESS_WIDTH-1:0] ram_add,
  output logic [DATA_WIDTH-1:0]    ram_data_in,
  input  logic [DATA_WIDTH-1:0]    ram_data_out
);

  localparam logic [ADDRESS_WIDTH:0] DepthLim = DEPTH[ADDRESS_WIDTH:0];

  state_e                   state_q, state_d;
  grant_e                   last_grant_q, last_grant_d;
  logic [ADDRESS_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                     rsp_valid_q;
  logic [DATA_WIDTH-1:0]    rsp_data_q;
  logic                     err_q, err_d;
  logic                     grant_wr, grant_rd;
  logic                     wr_ok, rd_ok;

  assign wr_ok = {1'b0, wr_addr} < DepthLim;
  assign rd_ok = {1'b0, rd_addr} < DepthLim;

  // Round-robin arbiter; in the capture cycle only a lone read may pipeline behind it.
  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (rst_n) begin
      if (state_q == StCapt) begin
        grant_rd = rd_valid & ~wr_valid;
      end else if (wr_valid && rd_valid) begin
        grant_wr = (last_grant_q == GntRd);
        grant_rd = (last_grant_q == GntWr);
      end else begin
        grant_wr = wr_valid;
        grant_rd = rd_valid;
      end
    end
  end

  always_comb begin
    wr_ready     = grant_wr;
    rd_ready     = grant_rd;
    state_d      = StIdle;
    last_grant_d = last_grant_q;
    rd_addr_d    = rd_addr_q;
    err_d        = 1'b0;
    ram_en       = 1'b0;
    ram_w_r      = W_R_READ;
    ram_add      = '0;
    ram_data_in  = '0;

    // Keep the RAM output enabled so the previous read's data can be captured.
    if (rst_n && state_q == StCapt) begin
      ram_en  = 1'b1;
      ram_add = rd_addr_q;
    end

    if (grant_wr) begin
      last_grant_d = GntWr;
      if (wr_ok) begin
        ram_en      = 1'b1;
        ram_w_r     = W_R_WRITE;
        ram_add     = wr_addr;
        ram_data_in = wr_data;
      end else begin
        err_d = 1'b1;
      end
    end

    if (grant_rd) begin
      last_grant_d = GntRd;
      if (rd_ok) begin
        ram_en    = 1'b1;
        ram_add   = rd_addr;
        rd_addr_d = rd_addr;
        state_d   = StCapt;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= GntRd;
      rd_addr_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rd_addr_q    <= rd_addr_d;
      rsp_valid_q  <= (state_q == StCapt);
      if (state_q == StCapt) rsp_data_q <= ram_data_out;
      err_q        <= err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign err_addr  = err_q;

endmodule

// File: tb/tb_sp_ram_ctrl.sv
// Bench for sp_ram_ctrl driving a real sp_ram; directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_sp_ram_ctrl;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_valid, wr_ready, rd_valid, rd_ready;
  logic [AW-1:0] wr_addr, rd_addr, ram_add;
  logic [DW-1:0] wr_data, rsp_data, ram_data_in;
  logic          rsp_valid, err_addr, ram_en, ram_w_r;
  wire  [DW-1:0] ram_data_out;

  always #5 clk = ~clk;

  sp_ram_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .err_addr(err_addr),
    .ram_en(ram_en), .ram_w_r(ram_w_r), .ram_add(ram_add), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out)
  );

  sp_ram #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) ram (
    .clk(clk), .en(ram_en), .w_r(ram_w_r), .add(ram_add), .data_in(ram_data_in),
    .data_out(ram_data_out)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: memory contents, arbitration history and scheduled outputs by cycle.
  typedef struct {int due; logic [DW-1:0] data;} rsp_t;
  logic [DW-1:0] m_mem [16];
  bit            m_capt;
  bit            m_last_rd;
  logic [AW-1:0] m_held;
  logic [DW-1:0] m_rsp_data;
  rsp_t          rsp_q[$];
  int            err_q[$];
  int            cyc = 0;

  function automatic bit addr_ok(logic [AW-1:0] a);
    return int'(a) < int'(DEPTH);
  endfunction

  task automatic model_grants(output bit wg, output bit rg);
    wg = 1'b0;
    rg = 1'b0;
    if (rst_n) begin
      if (m_capt) begin
        rg = rd_valid && !wr_valid;
      end else if (wr_valid && rd_valid) begin
        wg = m_last_rd;
        rg = !m_last_rd;
      end else begin
        wg = wr_valid;
        rg = rd_valid;
      end
    end
  endtask

  task automatic tick();
    bit   wg, rg, nxt;
    rsp_t r;
    model_grants(wg, rg);
    nxt = 1'b0;
    if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
      m_rsp_data = rsp_q[0].data;
      void'(rsp_q.pop_front());
    end
    if (err_q.size() > 0 && err_q[0] == cyc) void'(err_q.pop_front());
    if (!rst_n) begin
      m_capt = 1'b0;
      m_last_rd = 1'b1;
      rsp_q.delete();
      err_q.delete();
      m_rsp_data = '0;
    end else begin
      if (wg) begin
        m_last_rd = 1'b0;
        if (addr_ok(wr_addr)) m_mem[wr_addr] = wr_data;
        else err_q.push_back(cyc + 1);
      end
      if (rg) begin
        m_last_rd = 1'b1;
        if (addr_ok(rd_addr)) begin
          r.due = cyc + 2;
          r.data = m_mem[rd_addr];
          rsp_q.push_back(r);
          m_held = rd_addr;
          nxt = 1'b1;
        end else begin
          err_q.push_back(cyc + 1);
        end
      end
      m_capt = nxt;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input bit wv, input int wa, input int wd, input bit rv, input int ra);
    wr_valid = wv;
    wr_addr  = wa[AW-1:0];
    wr_data  = wd[DW-1:0];
    rd_valid = rv;
    rd_addr  = ra[AW-1:0];
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 0, 0, 1'b0, 0);
    tick();
    tick();
    drive(1'b0, 0, 0, 1'b0, 0);
    n_chk++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); end
    n_chk++; if (rsp_data !== 8'h00) begin n_err++; $display("FAIL rst_rsp_data got %h want 00", rsp_data); end
    n_chk++; if (err_addr !== 1'b0) begin n_err++; $display("FAIL rst_err got %b want 0", err_addr); end
    n_chk++; if ({ram_en, ram_w_r, wr_ready, rd_ready} !== 4'b0000) begin
      n_err++; $display("FAIL rst_ctrl got %b want 0000", {ram_en, ram_w_r, wr_ready, rd_ready});
    end
    n_chk++; if ({ram_add, ram_data_in} !== 12'h000) begin
      n_err++; $display("FAIL rst_bus got %h want 000", {ram_add, ram_data_in});
    end
    rst_n = 1'b1;
    drive(1'b0, 0, 0, 1'b0, 0);
    n_chk++; if (ram_en !== 1'b0) begin n_err++; $display("FAIL idle_en got %b want 0", ram_en); end
    tick();
  endtask

  task automatic test_write_read();
    drive(1'b1, 3, 'hA5, 1'b0, 0);
    n_chk++; if ({wr_ready, ram_en, ram_w_r} !== 3'b111) begin
      n_err++; $display("FAIL wr_grant got %b want 111", {wr_ready, ram_en, ram_w_r});
    end
    n_chk++; if ({ram_add, ram_data_in} !== 12'h3A5) begin
      n_err++; $display("FAIL wr_bus got %h want 3a5", {ram_add, ram_data_in});
    end
    tick();
    drive(1'b0, 0, 0, 1'b1, 3);
    n_chk++; if ({rd_ready, ram_en, ram_w_r} !== 3'b110) begin
      n_err++; $display("FAIL rd_grant got %b want 110", {rd_ready, ram_en, ram_w_r});
    end
    tick();
    drive(1'b0, 0, 0, 1'b0, 0);
    n_chk++; if ({ram_en, ram_w_r, rsp_valid} !== 3'b100) begin
      n_err++; $display("FAIL rd_capt got %b want 100", {ram_en, ram_w_r, rsp_valid});
    end
    tick();
    drive(1'b0, 0, 0, 1'b0, 0);
    n_chk++; if ({rsp_valid, rsp_data} !== 9'h1A5) begin
      n_err++; $display("FAIL rd_rsp got %h want 1a5", {rsp_valid, rsp_data});
    end
    tick();
    drive(1'b0, 0, 0, 1'b0, 0);
    n_chk++; if ({rsp_valid, rsp_data} !== 9'h0A5) begin
      n_err++; $display("FAIL rsp_hold got %h want 0a5", {rsp_valid, rsp_data});
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, i, 'h10 + i, 1'b0, 0);
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      bit   want_rdy = (i < 3);
      bit   want_rv  = (i >= 2 && i < 5);
      logic [DW-1:0] want_d = DW'(8'h10 + i - 2);
      drive(1'b0, 0, 0, want_rdy, i);
      n_chk++; if (rd_ready !== want_rdy || ram_w_r !== 1'b0) begin
        n_err++; $display("FAIL b2b_rdy[%0d] got rdy=%b w_r=%b want rdy=%b w_r=0",
                          i, rd_ready, ram_w_r, want_rdy);
      end
      n_chk++; if (rsp_valid !== want_rv || (want_rv && rsp_data !== want_d)) begin
        n_err++; $display("FAIL b2b_rsp[%0d] got v=%b d=%h want v=%b d=%h",
                          i, rsp_valid, rsp_data, want_rv, want_d);
      end
      tick();
    end
  endtask

  task automatic test_contention();
    logic [5:0] exp_wr = 6'b001001;
    logic [5:0] exp_rd = 6'b010010;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 8, 'h40 + i, 1'b1, 2);
      n_chk++; if (wr_ready !== exp_wr[i] || rd_ready !== exp_rd[i]) begin
        n_err++; $display("FAIL rr[%0d] got wr=%b rd=%b want wr=%b rd=%b",
                          i, wr_ready, rd_ready, exp_wr[i], exp_rd[i]);
      end
      n_chk++; if (ram_w_r !== exp_wr[i] || ram_en !== 1'b1) begin
        n_err++; $display("FAIL rr_port[%0d] got en=%b w_r=%b want en=1 w_r=%b",
                          i, ram_en, ram_w_r, exp_wr[i]);
      end
      tick();
    end
    drive(1'b0, 0, 0, 1'b0, 0);
    n_chk++; if ({rsp_valid, rsp_data} !== 9'h112) begin
      n_err++; $display("FAIL rr_rsp got %h want 112", {rsp_valid, rsp_data});
    end
    tick();
    tick();
  endtask

  task automatic test_capt_write();
    drive(1'b1, 5, 'h77, 1'b0, 0);
    tick();
    drive(1'b0, 0, 0, 1'b1, 5);
    n_chk++; if (rd_ready !== 1'b1) begin n_err++; $display("FAIL cw_rd got %b want 1", rd_ready); end
    tick();
    drive(1'b1, 9, 'h3C, 1'b0, 0);
    n_chk++; if ({ram_en, ram_w_r, wr_ready, rd_ready} !== 4'b1000 || ram_add !== 4'd5) begin
      n_err++; $display("FAIL cw_capt got en/wr/wrdy/rrdy=%b add=%0d want 1000 add=5",
                        {ram_en, ram_w_r, wr_ready, rd_ready}, ram_add);
    end
    tick();
    drive(1'b1, 9, 'h3C, 1'b0, 0);
    n_chk++; if ({wr_ready, ram_en, ram_w_r} !== 3'b111 || ram_add !== 4'd9) begin
      n_err++; $display("FAIL cw_wr got %b add=%0d want 111 add=9",
                        {wr_ready, ram_en, ram_w_r}, ram_add);
    end
    n_chk++; if ({rsp_valid, rsp_data} !== 9'h177) begin
      n_err++; $display("FAIL cw_rsp got %h want 177", {rsp_valid, rsp_data});
    end
    tick();
  endtask

  task automatic test_bad_addr();
    drive(1'b1, 14, 'hEE, 1'b0, 0);
    n_chk++; if ({wr_ready, ram_en} !== 2'b10) begin
      n_err++; $display("FAIL bad_wr got rdy/en=%b want 10", {wr_ready, ram_en});
    end
    tick();
    drive(1'b0, 0, 0, 1'b0, 0);
    n_chk++; if (err_addr !== 1'b1) begin n_err++; $display("FAIL bad_wr_err got %b want 1", err_addr); end
    tick();
    drive(1'b0, 0, 0, 1'b1, 14);
    n_chk++; if ({rd_ready, ram_en, err_addr} !== 3'b100) begin
      n_err++; $display("FAIL bad_rd got rdy/en/err=%b want 100", {rd_ready, ram_en, err_addr});
    end
    tick();
    drive(1'b0, 0, 0, 1'b0, 0);
    n_chk++; if ({err_addr, ram_en, rsp_valid} !== 3'b100) begin
      n_err++; $display("FAIL bad_rd_err got err/en/v=%b want 100", {err_addr, ram_en, rsp_valid});
    end
    tick();
    drive(1'b0, 0, 0, 1'b0, 0);
    n_chk++; if ({err_addr, rsp_valid} !== 2'b00) begin
      n_err++; $display("FAIL bad_rd_quiet got err/v=%b want 00", {err_addr, rsp_valid});
    end
    tick();
  endtask

  task automatic test_reset_mid_read();
    drive(1'b0, 0, 0, 1'b1, 0);
    tick();
    rst_n = 1'b0;
    drive(1'b0, 0, 0, 1'b0, 0);
    tick();
    drive(1'b0, 0, 0, 1'b0, 0);
    n_chk++; if ({rsp_valid, rsp_data} !== 9'h000 || {ram_en, err_addr} !== 2'b00) begin
      n_err++; $display("FAIL mid_rst got v/d=%h en/err=%b want 000 00",
                        {rsp_valid, rsp_data}, {ram_en, err_addr});
    end
    rst_n = 1'b1;
    drive(1'b1, 6, 'h5A, 1'b0, 0);
    n_chk++; if ({wr_ready, ram_en, ram_w_r} !== 3'b111) begin
      n_err++; $display("FAIL post_rst_wr got %b want 111", {wr_ready, ram_en, ram_w_r});
    end
    tick();
    drive(1'b0, 0, 0, 1'b1, 6);
    n_chk++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_stale got %b want 0", rsp_valid); end
    tick();
    drive(1'b0, 0, 0, 1'b0, 0);
    tick();
    drive(1'b0, 0, 0, 1'b0, 0);
    n_chk++; if ({rsp_valid, rsp_data} !== 9'h15A) begin
      n_err++; $display("FAIL post_rst_rsp got %h want 15a", {rsp_valid, rsp_data});
    end
    tick();
  endtask

  task automatic test_random();
    bit            wg, rg, e_en, e_wr, e_rv, e_err;
    logic [AW-1:0] e_add;
    logic [DW-1:0] e_rd;
    for (int a = 0; a < int'(DEPTH); a++) begin
      drive(1'b1, a, int'($urandom_range(0, 255)), 1'b0, 0);
      tick();
    end
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 99) < 55, int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
            $urandom_range(0, 99) < 60, int'($urandom_range(0, 15)));
      model_grants(wg, rg);
      e_wr  = wg && addr_ok(wr_addr);
      e_en  = m_capt || e_wr || (rg && addr_ok(rd_addr));
      e_add = e_wr ? wr_addr : ((rg && addr_ok(rd_addr)) ? rd_addr : m_held);
      e_rv  = rsp_q.size() > 0 && rsp_q[0].due == cyc;
      e_rd  = e_rv ? rsp_q[0].data : m_rsp_data;
      e_err = err_q.size() > 0 && err_q[0] == cyc;
      n_chk++; if (wr_ready !== wg || rd_ready !== rg) begin
        n_err++; $display("FAIL rnd_grant[%0d] got wr=%b rd=%b want wr=%b rd=%b",
                          i, wr_ready, rd_ready, wg, rg);
      end
      n_chk++; if (ram_en !== e_en || ram_w_r !== e_wr) begin
        n_err++; $display("FAIL rnd_port[%0d] got en=%b w_r=%b want en=%b w_r=%b",
                          i, ram_en, ram_w_r, e_en, e_wr);
      end
      n_chk++; if (e_en && (ram_add !== e_add || (e_wr && ram_data_in !== wr_data))) begin
        n_err++; $display("FAIL rnd_bus[%0d] got add=%0d din=%h want add=%0d din=%h",
                          i, ram_add, ram_data_in, e_add, wr_data);
      end
      n_chk++; if (rsp_valid !== e_rv || rsp_data !== e_rd) begin
        n_err++; $display("FAIL rnd_rsp[%0d] got v=%b d=%h want v=%b d=%h",
                          i, rsp_valid, rsp_data, e_rv, e_rd);
      end
      n_chk++; if (err_addr !== e_err) begin
        n_err++; $display("FAIL rnd_err[%0d] got %b want %b", i, err_addr, e_err);
      end
      tick();
    end
  endtask

  initial begin
    m_capt     = 1'b0;
    m_last_rd  = 1'b1;
    m_held     = '0;
    m_rsp_data = '0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_contention();
    test_capt_write();
    test_bad_addr();
    test_reset_mid_read();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sp_ram_ctrl.md
Name: sp_ram_ctrl

Overview:
Request front-end for the single-port RAM. It takes independent write and read request streams over valid/ready and arbitrates them onto the one RAM port (en, w_r, add, data_in). It sequences reads so the RAM's gated data_out is driven in the capture cycle, and returns registered read responses. It sits directly upstream of sp_ram and is the only driver of its control pins.

Parameters:
ADDRESS_WIDTH, 4, RAM address width
DATA_WIDTH, 8, RAM data width
DEPTH, 16, RAM depth; addresses at or above DEPTH are rejected

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  synchronous active-low reset
wr_valid  input  1  write request present
wr_ready  output  1  write request accepted this cycle
wr_addr  input  ADDRESS_WIDTH  write address
wr_data  input  DATA_WIDTH  write data
rd_valid  input  1  read request present
rd_ready  output  1  read request accepted this cycle
rd_addr  input  ADDRESS_WIDTH  read address
rsp_valid  output  1  read response valid, 1-cycle pulse, no backpressure
rsp_data  output  DATA_WIDTH  read response data
err_addr  output  1  1-cycle pulse: an accepted request had address >= DEPTH, dropped
ram_en  output  1  to RAM en
ram_w_r  output  1  to RAM w_r (1 = write, 0 = read)
ram_add  output  ADDRESS_WIDTH  to RAM add
ram_data_in  output  DATA_WIDTH  to RAM data_in
ram_data_out  input  DATA_WIDTH  from RAM data_out (high-Z unless en & ~w_r)

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, last_grant=READ, wr_ready=rd_ready=0, rsp_valid=0, rsp_data=0, err_addr=0, ram_en=0, ram_w_r=0, ram_add=0, ram_data_in=0. Reset mid-read discards the in-flight response; no rsp_valid follows.
- RAM-side outputs are combinational from the current grant, so the RAM samples them at the end of the grant cycle. wr_ready and rd_ready are combinational grants; a handshake is valid & ready in the same cycle.
- States: IDLE (no read in flight) and CAPT (the cycle after a read grant; RAM data_out carries that read's data).
- IDLE grant rule:
  - Only wr_valid: grant the write.
  - Only rd_valid: grant the read.
  - Both: grant the opposite of last_grant (round-robin).
  - A granted read moves to CAPT; otherwise stay in IDLE.
- CAPT rule:
  - ram_en=1 and ram_w_r=0 are forced, because the RAM output is only driven while en & ~w_r.
  - If rd_valid and !wr_valid: grant the read, ram_add=rd_addr (pipelined read), stay in CAPT.
  - Otherwise: ram_add holds the previous read address (harmless re-read), wr_ready=0, rd_ready=0, go to IDLE. A pending write is therefore granted next cycle by round-robin, since last_grant=READ.
- No grant and not CAPT: ram_en=0.
- Write: ram_en=1, ram_w_r=1, ram_add=wr_addr, ram_data_in=wr_data. Memory updates at the end of the grant cycle. A read granted in the next cycle to the same address returns the new data.
- Read latency: grant in cycle T; ram_data_out is valid in T+1 and is registered into rsp_data at the end of T+1; rsp_valid=1 during T+2. Back-to-back reads give one response per cycle, in order.
- rsp_data holds its last value when rsp_valid=0.
- Address check:
  - An accepted request with address >= DEPTH is handshaken (ready=1) but not issued: ram_en=0 for a write, and no CAPT for a read.
  - err_addr pulses the next cycle. No rsp_valid is produced for a dropped read.
  - last_grant still updates.
- last_grant updates on every accepted request.
- Throughput:
  - Reads only: 1 per cycle.
  - Writes only: 1 per cycle.
  - Alternating contention: the read-to-write turnaround costs the CAPT cycle.

Decomposition:
- Package sp_ram_pkg:
  - W_R_WRITE=1'b1, W_R_READ=1'b0.
  - State encoding IDLE/CAPT.
  - Grant encoding GNT_WR/GNT_RD.
- No sub-module. The arbiter is a few lines of combinational logic inside the block.
- The testbench instantiates sp_ram_ctrl wired to sp_ram with matching parameters.

Test Plan:
- Write 0xA5 to addr 3, then read addr 3 next cycle -> rsp_valid 2 cycles after rd grant, rsp_data=0xA5.
- Reads to addr 0,1,2 back-to-back (preloaded 0x10,0x11,0x12) -> rd_ready=1 each cycle; rsp_valid in 3 consecutive cycles with 0x10,0x11,0x12; ram_w_r=0 throughout.
- wr_valid and rd_valid both held high for 6 cycles -> a write is granted in the cycle after each read's CAPT cycle, so reads and writes alternate with no starvation, and ram_w_r is never 1 in a cycle following a read grant.
- Read addr 5 (0x77) with wr_valid asserted during the CAPT cycle -> the CAPT cycle shows ram_en=1, ram_w_r=0, wr_ready=0; the write is granted in the next cycle; rsp_data=0x77.
- With DEPTH=12, write to addr 14 -> wr_ready=1, ram_en=0, err_addr pulses the next cycle; a later read of addr 14 gives err_addr and no rsp_valid.
- rst_n=0 during a read's CAPT cycle -> next cycle all outputs at reset values, no rsp_valid; the first request after release is handled from IDLE.
